// File: rtl/mux_from_rs2_to_mem_if.sv
// rtl/mux_from_rs2_to_mem_if.sv - store-data formatter bus between datapath and data memory
interface mux_from_rs2_to_mem_if #(
  parameter int XLEN = 32
);
  logic [1:0]      mrs2_ctr;
  logic [XLEN-1:0] rs2;
  logic [1:0]      addr_lo;
  logic            store_en;
  logic [XLEN-1:0] mrs2_out;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            misalign;
  logic [XLEN-1:0] mem_wdata_q;
  logic [3:0]      mem_be_q;
  logic            misalign_q;

  modport master (
    output mrs2_ctr, rs2, addr_lo, store_en,
    input  mrs2_out, mem_wdata, mem_be, misalign,
    input  mem_wdata_q, mem_be_q, misalign_q
  );

  modport slave (
    input  mrs2_ctr, rs2, addr_lo, store_en,
    output mrs2_out, mem_wdata, mem_be, misalign,
    output mem_wdata_q, mem_be_q, misalign_q
  );
endinterface

// File: rtl/mux_from_rs2_to_mem.sv
// rtl/mux_from_rs2_to_mem.sv - rs2 store-data select, lane replication and byte enables
module mux_from_rs2_to_mem #(
  parameter int XLEN    = 32,
  parameter bit REG_OUT = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  mux_from_rs2_to_mem_if.slave bus
);
  localparam logic [1:0] CTR_WORD = 2'b00;
  localparam logic [1:0] CTR_BYTE = 2'b01;
  localparam logic [1:0] CTR_HALF = 2'b10;

  logic [XLEN-1:0] w_mrs2_out;
  logic [XLEN-1:0] w_mem_wdata;
  logic [3:0]      w_be_raw;
  logic            w_misalign;
  logic [3:0]      w_mem_be;

  always_comb begin
    w_mrs2_out  = '0;
    w_mem_wdata = '0;
    w_be_raw    = 4'b0000;
    case (bus.mrs2_ctr)
      CTR_WORD: begin
        w_mrs2_out  = bus.rs2;
        w_mem_wdata = bus.rs2;
        w_be_raw    = (bus.addr_lo == 2'd0) ? 4'b1111 : 4'b0000;
      end
      CTR_BYTE: begin
        w_mrs2_out  = {24'b0, bus.rs2[7:0]};
        w_mem_wdata = {4{bus.rs2[7:0]}};
        w_be_raw    = 4'b0001 << bus.addr_lo;
      end
      CTR_HALF: begin
        w_mrs2_out  = {16'b0, bus.rs2[15:0]};
        w_mem_wdata = {2{bus.rs2[15:0]}};
        case (bus.addr_lo)
          2'd0:    w_be_raw = 4'b0011;
          2'd2:    w_be_raw = 4'b1100;
          default: w_be_raw = 4'b0000;
        endcase
      end
      default: begin
        w_mrs2_out  = '0;
        w_mem_wdata = '0;
        w_be_raw    = 4'b0000;
      end
    endcase
  end

  assign w_misalign = bus.store_en &
                      (((bus.mrs2_ctr == CTR_WORD) && (bus.addr_lo != 2'd0)) ||
                       ((bus.mrs2_ctr == CTR_HALF) && bus.addr_lo[0]));
  // Misaligned and reserved cases already yield zero enables, so gating by store_en suffices.
  assign w_mem_be   = bus.store_en ? w_be_raw : 4'b0000;

  assign bus.mrs2_out  = w_mrs2_out;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_be    = w_mem_be;
  assign bus.misalign  = w_misalign;

  generate
    if (REG_OUT) begin : g_reg
      logic [XLEN-1:0] r_mem_wdata_q;
      logic [3:0]      r_mem_be_q;
      logic            r_misalign_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem_wdata_q <= '0;
          r_mem_be_q    <= 4'b0000;
          r_misalign_q  <= 1'b0;
        end else begin
          r_mem_wdata_q <= w_mem_wdata;
          r_mem_be_q    <= w_mem_be;
          r_misalign_q  <= w_misalign;
        end
      end

      assign bus.mem_wdata_q = r_mem_wdata_q;
      assign bus.mem_be_q    = r_mem_be_q;
      assign bus.misalign_q  = r_misalign_q;
    end else begin : g_comb
      assign bus.mem_wdata_q = w_mem_wdata;
      assign bus.mem_be_q    = w_mem_be;
      assign bus.misalign_q  = w_misalign;
    end
  endgenerate
endmodule

// File: tb/tb_mux_from_rs2_to_mem.sv
// tb/tb_mux_from_rs2_to_mem.sv - directed-vector bench for the rs2 store formatter
module tb_mux_from_rs2_to_mem;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  mux_from_rs2_to_mem_if #(.XLEN(32)) bus ();

  mux_from_rs2_to_mem #(.XLEN(32), .REG_OUT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ctr, input logic [31:0] d,
                       input logic [1:0] a, input logic en);
    bus.mrs2_ctr = ctr;
    bus.rs2      = d;
    bus.addr_lo  = a;
    bus.store_en = en;
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(2'b00, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    chk("rst_wdata_q", bus.mem_wdata_q, 32'h0);
    chk("rst_be_q", {28'b0, bus.mem_be_q}, 32'h0);
    chk("rst_mis_q", {31'b0, bus.misalign_q}, 32'h0);

    // combinational checks while reset is held: no clock dependence
    drive(2'b00, 32'h0000_0001, 2'd0, 1'b0);
    chk("sw_out", bus.mrs2_out, 32'h0000_0001);

    drive(2'b01, 32'h0000_00F1, 2'd3, 1'b1);
    chk("sb_out", bus.mrs2_out, 32'h0000_00F1);
    chk("sb_wdata", bus.mem_wdata, 32'hF1F1_F1F1);
    chk("sb_be3", {28'b0, bus.mem_be}, 32'h8);
    chk("sb_mis", {31'b0, bus.misalign}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      drive(2'b01, 32'h1234_5678, a[1:0], 1'b1);
      chk("sb_be_lane", {28'b0, bus.mem_be}, 32'h1 << a);
      chk("sb_wdata_rep", bus.mem_wdata, 32'h7878_7878);
    end

    drive(2'b10, 32'hDEAD_BEEF, 2'd2, 1'b1);
    chk("sh_out", bus.mrs2_out, 32'h0000_BEEF);
    chk("sh_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
    chk("sh_be2", {28'b0, bus.mem_be}, 32'hC);
    chk("sh_mis2", {31'b0, bus.misalign}, 32'h0);
    drive(2'b10, 32'hDEAD_BEEF, 2'd0, 1'b1);
    chk("sh_be0", {28'b0, bus.mem_be}, 32'h3);
    drive(2'b10, 32'hDEAD_BEEF, 2'd1, 1'b1);
    chk("sh_mis1", {31'b0, bus.misalign}, 32'h1);
    chk("sh_be1", {28'b0, bus.mem_be}, 32'h0);

    drive(2'b11, 32'hFFFF_FFFF, 2'd0, 1'b1);
    chk("rsv_out", bus.mrs2_out, 32'h0);
    chk("rsv_wdata", bus.mem_wdata, 32'h0);
    chk("rsv_be", {28'b0, bus.mem_be}, 32'h0);
    chk("rsv_mis", {31'b0, bus.misalign}, 32'h0);

    drive(2'b00, 32'hCAFE_F00D, 2'd0, 1'b0);
    chk("noen_be", {28'b0, bus.mem_be}, 32'h0);
    chk("noen_out", bus.mrs2_out, 32'hCAFE_F00D);
    drive(2'b00, 32'hCAFE_F00D, 2'd1, 1'b0);
    chk("noen_mis", {31'b0, bus.misalign}, 32'h0);
    drive(2'b00, 32'hCAFE_F00D, 2'd1, 1'b1);
    chk("sw_mis", {31'b0, bus.misalign}, 32'h1);
    chk("sw_mis_be", {28'b0, bus.mem_be}, 32'h0);

    // registered path
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b00, 32'h1234_5678, 2'd0, 1'b1);
    chk("pre_edge_be_q", {28'b0, bus.mem_be_q}, 32'h0);
    @(negedge clk);
    chk("q_be", {28'b0, bus.mem_be_q}, 32'hF);
    chk("q_wdata", bus.mem_wdata_q, 32'h1234_5678);
    chk("q_mis", {31'b0, bus.misalign_q}, 32'h0);

    drive(2'b10, 32'h0000_ABCD, 2'd3, 1'b1);
    @(negedge clk);
    chk("q_mis_h", {31'b0, bus.misalign_q}, 32'h1);
    chk("q_be_h", {28'b0, bus.mem_be_q}, 32'h0);
    chk("q_wdata_h", bus.mem_wdata_q, 32'hABCD_ABCD);

    drive(2'b00, 32'h1234_5678, 2'd0, 1'b1);
    @(negedge clk);
    chk("q_be_again", {28'b0, bus.mem_be_q}, 32'hF);
    rst_n = 1'b0;
    #1;
    chk("arst_be_q", {28'b0, bus.mem_be_q}, 32'h0);
    chk("arst_wdata_q", bus.mem_wdata_q, 32'h0);
    chk("arst_mis_q", {31'b0, bus.misalign_q}, 32'h0);
    chk("arst_be_comb", {28'b0, bus.mem_be}, 32'hF);
    chk("arst_wdata_comb", bus.mem_wdata, 32'h1234_5678);
    @(negedge clk);
    chk("held_rst_be_q", {28'b0, bus.mem_be_q}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
